// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b definitions: widths, running-disparity encoding, K-code bytes
// and a ones-count helper used by the decoder.
package enc8b10b_pkg;

    localparam int SYM_W  = 10;
    localparam int BYTE_W = 8;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    typedef enum logic {
        ST_RD_NEG = RD_NEG,
        ST_RD_POS = RD_POS
    } rd_state_t;

    localparam logic [4:0]        K28_EDCBA  = 5'd28;
    localparam logic [BYTE_W-1:0] K28_5_BYTE = 8'hBC;
    localparam logic [BYTE_W-1:0] K23_7_BYTE = 8'hF7;
    localparam logic [BYTE_W-1:0] K27_7_BYTE = 8'hFB;
    localparam logic [BYTE_W-1:0] K29_7_BYTE = 8'hFD;
    localparam logic [BYTE_W-1:0] K30_7_BYTE = 8'hFE;

    function automatic logic [3:0] ones10(input logic [SYM_W-1:0] sym);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < SYM_W; i++) begin
            n = n + 4'(sym[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dec_6b5b.sv
// 6b/5b sub-block decoder: maps abcdei (either RD form) to EDCBA and flags
// the K28 sub-block, which the 4b/3b stage needs to pick its table.
module dec_6b5b
    import enc8b10b_pkg::*;
(
    input  logic [5:0] i_abcdei,
    output logic [4:0] o_edcba,
    output logic       o_valid,
    output logic       o_k28
);

    always_comb begin
        o_edcba = '0;
        o_valid = 1'b1;
        o_k28   = 1'b0;
        case (i_abcdei)
            6'b100111, 6'b011000: o_edcba = 5'd0;
            6'b011101, 6'b100010: o_edcba = 5'd1;
            6'b101101, 6'b010010: o_edcba = 5'd2;
            6'b110001:            o_edcba = 5'd3;
            6'b110101, 6'b001010: o_edcba = 5'd4;
            6'b101001:            o_edcba = 5'd5;
            6'b011001:            o_edcba = 5'd6;
            6'b111000, 6'b000111: o_edcba = 5'd7;
            6'b111001, 6'b000110: o_edcba = 5'd8;
            6'b100101:            o_edcba = 5'd9;
            6'b010101:            o_edcba = 5'd10;
            6'b110100:            o_edcba = 5'd11;
            6'b001101:            o_edcba = 5'd12;
            6'b101100:            o_edcba = 5'd13;
            6'b011100:            o_edcba = 5'd14;
            6'b010111, 6'b101000: o_edcba = 5'd15;
            6'b011011, 6'b100100: o_edcba = 5'd16;
            6'b100011:            o_edcba = 5'd17;
            6'b010011:            o_edcba = 5'd18;
            6'b110010:            o_edcba = 5'd19;
            6'b001011:            o_edcba = 5'd20;
            6'b101010:            o_edcba = 5'd21;
            6'b011010:            o_edcba = 5'd22;
            6'b111010, 6'b000101: o_edcba = 5'd23;
            6'b110011, 6'b001100: o_edcba = 5'd24;
            6'b100110:            o_edcba = 5'd25;
            6'b010110:            o_edcba = 5'd26;
            6'b110110, 6'b001001: o_edcba = 5'd27;
            6'b001110:            o_edcba = 5'd28;
            6'b101110, 6'b010001: o_edcba = 5'd29;
            6'b011110, 6'b100001: o_edcba = 5'd30;
            6'b101011, 6'b010100: o_edcba = 5'd31;
            6'b001111, 6'b110000: begin
                o_edcba = K28_EDCBA;
                o_k28   = 1'b1;
            end
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/decoder_10b8b.sv
// 10b/8b decoder: stage 1 captures the symbol and its ones count, stage 2
// decodes, checks disparity against the RD state and registers the results.
// state     | meaning
// ST_RD_NEG | running disparity negative (reset / restart value)
// ST_RD_POS | running disparity positive
module decoder_10b8b
    import enc8b10b_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              startin,
    input  logic              pushin,
    input  logic [SYM_W-1:0]  datain,
    output logic              pushout,
    output logic [BYTE_W-1:0] dataout,
    output logic              kout,
    output logic              code_err,
    output logic              disp_err,
    output logic              rdout
);

    logic              r_s1_valid;
    logic [SYM_W-1:0]  r_s1_sym;
    logic [3:0]        r_s1_ones;
    rd_state_t         r_rd;
    rd_state_t         w_rd_next;
    logic              r_pushout, r_kout, r_code_err, r_disp_err, r_rdout;
    logic [BYTE_W-1:0] r_dataout;

    logic [4:0]        w_edcba;
    logic              w_v6, w_k28, w_v4, w_kx7, w_k;
    logic [2:0]        w_hgf;
    logic [3:0]        w_fghj_n;
    logic              w_code_err, w_disp_err;
    logic [BYTE_W-1:0] w_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sym   <= '0;
            r_s1_ones  <= '0;
        end else if (startin) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= pushin;
            if (pushin) begin
                r_s1_sym  <= datain;
                r_s1_ones <= ones10(datain);
            end
        end
    end

    dec_6b5b u_dec_6b5b (
        .i_abcdei (r_s1_sym[9:4]),
        .o_edcba  (w_edcba),
        .o_valid  (w_v6),
        .o_k28    (w_k28)
    );

    // K28 in its RD+ form (i=0) carries a complemented 4b sub-block.
    assign w_fghj_n = (w_k28 && !r_s1_sym[4]) ? ~r_s1_sym[3:0] : r_s1_sym[3:0];

    always_comb begin
        w_hgf = '0;
        w_v4  = 1'b1;
        case (w_fghj_n)
            4'b1011, 4'b0100:                   w_hgf = 3'd0;
            4'b1001:                            w_hgf = 3'd1;
            4'b0101:                            w_hgf = 3'd2;
            4'b1100, 4'b0011:                   w_hgf = 3'd3;
            4'b1101, 4'b0010:                   w_hgf = 3'd4;
            4'b1010:                            w_hgf = 3'd5;
            4'b0110:                            w_hgf = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: w_hgf = 3'd7;
            default:                            w_v4  = 1'b0;
        endcase
        if (w_k28 && (w_fghj_n inside {4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b0001, 4'b0111}))
            w_v4 = 1'b0;
    end

    assign w_kx7 = (r_s1_sym[3:0] == 4'b0111 || r_s1_sym[3:0] == 4'b1000)
                 && ({3'b111, w_edcba} inside {K23_7_BYTE, K27_7_BYTE, K29_7_BYTE, K30_7_BYTE});

    assign w_code_err = (r_s1_ones < 4'd4) || (r_s1_ones > 4'd6) || !w_v6 || !w_v4;
    assign w_k        = !w_code_err && (w_k28 || w_kx7);
    assign w_byte     = w_code_err ? '0 : {w_hgf, w_edcba};
    assign w_disp_err = !w_code_err
                      && (((r_s1_ones == 4'd6) && (r_rd == ST_RD_POS))
                       || ((r_s1_ones == 4'd4) && (r_rd == ST_RD_NEG)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rd <= ST_RD_NEG;
        else        r_rd <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd;
        if (startin) begin
            w_rd_next = ST_RD_NEG;
        end else if (r_s1_valid && !w_code_err) begin
            if (r_s1_ones == 4'd6)      w_rd_next = ST_RD_POS;
            else if (r_s1_ones == 4'd4) w_rd_next = ST_RD_NEG;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pushout  <= 1'b0;
            r_dataout  <= '0;
            r_kout     <= 1'b0;
            r_code_err <= 1'b0;
            r_disp_err <= 1'b0;
            r_rdout    <= 1'b0;
        end else if (startin) begin
            r_pushout  <= 1'b0;
        end else begin
            r_pushout <= r_s1_valid;
            if (r_s1_valid) begin
                r_dataout  <= w_byte;
                r_kout     <= w_k;
                r_code_err <= w_code_err;
                r_disp_err <= w_disp_err;
                r_rdout    <= (w_rd_next == ST_RD_POS);
            end
        end
    end

    assign pushout  = r_pushout;
    assign dataout  = r_dataout;
    assign kout     = r_kout;
    assign code_err = r_code_err;
    assign disp_err = r_disp_err;
    assign rdout    = r_rdout;

endmodule

// File: tb/tb_decoder_10b8b.sv
// Bench for decoder_10b8b: directed literal cases plus randomized traffic
// checked every cycle against a table-driven reference built from encoder tables.
module tb_decoder_10b8b;

    logic       clk = 1'b0;
    logic       reset;
    logic       startin, pushin;
    logic [9:0] datain;
    logic       pushout, kout, code_err, disp_err, rdout;
    logic [7:0] dataout;

    always #5 clk = ~clk;

    decoder_10b8b dut (
        .clk      (clk),
        .reset    (reset),
        .startin  (startin),
        .pushin   (pushin),
        .datain   (datain),
        .pushout  (pushout),
        .dataout  (dataout),
        .kout     (kout),
        .code_err (code_err),
        .disp_err (disp_err),
        .rdout    (rdout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoder-direction tables (RD- column); RD+ forms are derived by rule.
    logic [5:0] e6n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                             6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                             6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                             6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                             6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                             6'b011110, 6'b101011};
    logic [3:0] e4n [8]  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] k4n [8]  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

    logic       d6v [64];
    logic [4:0] d6x [64];
    logic       d4v [16];
    logic [2:0] d4y [16];

    function automatic logic [5:0] e6p(input int x);
        return ($countones(e6n[x]) == 3 && x != 7) ? e6n[x] : ~e6n[x];
    endfunction

    function automatic logic [3:0] e4p(input int y);
        return ($countones(e4n[y]) == 2 && y != 3) ? e4n[y] : ~e4n[y];
    endfunction

    task automatic build_tables();
        for (int i = 0; i < 64; i++) begin d6v[i] = 1'b0; d6x[i] = '0; end
        for (int i = 0; i < 16; i++) begin d4v[i] = 1'b0; d4y[i] = '0; end
        for (int x = 0; x < 32; x++) begin
            d6v[e6n[x]] = 1'b1; d6x[e6n[x]] = 5'(x);
            d6v[e6p(x)] = 1'b1; d6x[e6p(x)] = 5'(x);
        end
        for (int y = 0; y < 8; y++) begin
            d4v[e4n[y]] = 1'b1; d4y[e4n[y]] = 3'(y);
            d4v[e4p(y)] = 1'b1; d4y[e4p(y)] = 3'(y);
        end
        d4v[4'b0111] = 1'b1; d4y[4'b0111] = 3'd7;
        d4v[4'b1000] = 1'b1; d4y[4'b1000] = 3'd7;
    endtask

    task automatic ref_decode(input logic [9:0] s, output logic err, output logic [7:0] b,
                              output logic k, output int ones);
        logic [5:0] s6;
        logic [3:0] s4;
        logic       v6, v4;
        int         x, y;
        s6 = s[9:4]; s4 = s[3:0];
        ones = $countones(s);
        v6 = 1'b0; v4 = 1'b0; x = 0; y = 0; k = 1'b0;
        if (s6 == 6'b001111 || s6 == 6'b110000) begin
            v6 = 1'b1; x = 28; k = 1'b1;
            for (int j = 0; j < 8; j++)
                if ((s6 == 6'b001111 && s4 == k4n[j]) || (s6 == 6'b110000 && s4 == ~k4n[j])) begin
                    v4 = 1'b1; y = j;
                end
        end else begin
            v6 = d6v[s6]; x = int'(d6x[s6]);
            v4 = d4v[s4]; y = int'(d4y[s4]);
            k  = (x == 23 || x == 27 || x == 29 || x == 30) && (s4 == 4'b0111 || s4 == 4'b1000);
        end
        err = (ones < 4) || (ones > 6) || !v6 || !v4;
        if (err) begin b = 8'h00; k = 1'b0; end
        else     b = {3'(y), 5'(x)};
    endtask

    // Reference pipeline and per-cycle comparison.
    logic       m_s1v = 1'b0, m_rd = 1'b0;
    logic [9:0] m_s1sym = '0;
    logic       e_push = 0, e_k = 0, e_cerr = 0, e_derr = 0, e_rd = 0;
    logic [7:0] e_data = '0;

    initial forever begin
        logic       err, k;
        logic [7:0] b;
        int         ones;
        @(posedge clk);
        if (!reset) begin
            m_s1v = 0; m_rd = 0;
            e_push = 0; e_data = 0; e_k = 0; e_cerr = 0; e_derr = 0; e_rd = 0;
        end else if (startin) begin
            m_s1v = 0; m_rd = 0; e_push = 0;
        end else begin
            e_push = m_s1v;
            if (m_s1v) begin
                ref_decode(m_s1sym, err, b, k, ones);
                e_data = b; e_k = k; e_cerr = err;
                e_derr = !err && ((ones == 6 && m_rd) || (ones == 4 && !m_rd));
                if (!err && ones == 6) m_rd = 1'b1;
                if (!err && ones == 4) m_rd = 1'b0;
                e_rd = m_rd;
            end
            m_s1v = pushin; m_s1sym = datain;
        end
        #1;
        chk("model_pushout", pushout, e_push);
        chk("model_dataout", dataout, e_data);
        chk("model_kout", kout, e_k);
        chk("model_code_err", code_err, e_cerr);
        chk("model_disp_err", disp_err, e_derr);
        chk("model_rdout", rdout, e_rd);
    end

    task automatic cycle_in(input logic p, input logic s, input logic [9:0] d);
        @(negedge clk);
        pushin = p; startin = s; datain = d;
    endtask

    task automatic check_out(input string name, input logic [7:0] b, input logic k,
                             input logic ce, input logic de, input logic rd);
        chk({name, "_pushout"}, pushout, 1'b1);
        chk({name, "_dataout"}, dataout, b);
        chk({name, "_kout"}, kout, k);
        chk({name, "_code_err"}, code_err, ce);
        chk({name, "_disp_err"}, disp_err, de);
        chk({name, "_rdout"}, rdout, rd);
    endtask

    function automatic logic [9:0] rand_sym();
        int         r, x, y;
        logic [5:0] six;
        logic [3:0] four;
        int         kx [4] = '{23, 27, 29, 30};
        r = $urandom_range(0, 99);
        if (r < 55) begin
            x = $urandom_range(0, 31); y = $urandom_range(0, 7);
            six = $urandom_range(0, 1) ? e6n[x] : e6p(x);
            if (y == 7 && $urandom_range(0, 1) == 1) four = $urandom_range(0, 1) ? 4'b0111 : 4'b1000;
            else                                      four = $urandom_range(0, 1) ? e4n[y] : e4p(y);
        end else if (r < 75) begin
            if ($urandom_range(0, 1) == 1) begin
                y = $urandom_range(0, 7);
                six  = $urandom_range(0, 1) ? 6'b001111 : 6'b110000;
                four = (six == 6'b001111) ? k4n[y] : ~k4n[y];
            end else begin
                x = kx[$urandom_range(0, 3)];
                if ($urandom_range(0, 1) == 1) begin six = e6n[x]; four = 4'b1000; end
                else                           begin six = e6p(x); four = 4'b0111; end
            end
        end else begin
            return 10'($urandom_range(0, 1023));
        end
        return {six, four};
    endfunction

    initial begin
        build_tables();
        reset = 1'b1; startin = 1'b0; pushin = 1'b0; datain = '0;
        #2 reset = 1'b0;
        #1;
        chk("reset_pushout", pushout, 1'b0);
        chk("reset_dataout", dataout, 8'h00);
        chk("reset_kout", kout, 1'b0);
        chk("reset_code_err", code_err, 1'b0);
        chk("reset_disp_err", disp_err, 1'b0);
        chk("reset_rdout", rdout, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        cycle_in(1, 0, 10'h0FA); cycle_in(0, 0, 0); cycle_in(0, 0, 0);
        check_out("k285_rdneg", 8'hBC, 1, 0, 0, 1);
        cycle_in(0, 0, 0);
        chk("hold_pushout", pushout, 1'b0);
        chk("hold_dataout", dataout, 8'hBC);

        cycle_in(0, 1, 0);
        cycle_in(1, 0, 10'h0FA); cycle_in(1, 0, 10'h305); cycle_in(0, 0, 0);
        check_out("alt_k285_a", 8'hBC, 1, 0, 0, 1);
        cycle_in(0, 0, 0);
        check_out("alt_k285_b", 8'hBC, 1, 0, 0, 0);

        cycle_in(1, 0, 10'h2AA); cycle_in(1, 0, 10'h274); cycle_in(0, 0, 0);
        check_out("d21_5", 8'hB5, 0, 0, 0, 0);
        cycle_in(0, 0, 0);
        check_out("d0_0", 8'h00, 0, 0, 0, 0);

        cycle_in(1, 0, 10'h0FA); cycle_in(1, 0, 10'h0FA); cycle_in(0, 0, 0);
        check_out("disp_first", 8'hBC, 1, 0, 0, 1);
        cycle_in(0, 0, 0);
        check_out("disp_second", 8'hBC, 1, 0, 1, 1);

        cycle_in(1, 0, 10'h000); cycle_in(1, 0, 10'h3A8); cycle_in(0, 0, 0);
        check_out("code_viol", 8'h00, 0, 1, 0, 1);
        cycle_in(0, 0, 0);
        check_out("k23_7", 8'hF7, 1, 0, 0, 1);

        cycle_in(1, 0, 10'h0FA); cycle_in(1, 1, 10'h305);
        cycle_in(0, 0, 0); chk("flush_0", pushout, 1'b0);
        cycle_in(0, 0, 0); chk("flush_1", pushout, 1'b0);
        cycle_in(0, 0, 0); chk("flush_2", pushout, 1'b0);
        cycle_in(1, 0, 10'h0FA); cycle_in(0, 0, 0); cycle_in(0, 0, 0);
        check_out("after_restart", 8'hBC, 1, 0, 0, 1);

        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) begin
                @(negedge clk);
                reset = 1'b0; pushin = 1'b0; startin = 1'b0;
                #1;
                chk("midreset_pushout", pushout, 1'b0);
                chk("midreset_dataout", dataout, 8'h00);
                chk("midreset_kout", kout, 1'b0);
                chk("midreset_rdout", rdout, 1'b0);
                @(negedge clk);
                reset = 1'b1;
            end
            cycle_in($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3, rand_sym());
        end
        repeat (4) cycle_in(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
